serial_byte_feeder: RTL

Upstream stage for the serial sequence detector. It accepts parallel bytes over a valid/ready handshake and serialises them, one bit per Clk, onto a single-bit stream that drives the detector's InA. A one-entry holding buffer lets consecutive bytes stream gaplessly. When the feeder has no data, it drives a fixed idle bit so the detector always sees a defined input.

---
 rtl/serial_byte_feeder_pkg.sv | 14 +
 rtl/serial_byte_feeder_if.sv | 25 ++
 rtl/serial_byte_feeder.sv | 96 +++++++++
 3 files changed

// File: rtl/serial_byte_feeder_pkg.sv
// Shared constants for the feeder and the sequence detector downstream.
// The detector pattern lives here so both benches drive the same word.
package serial_byte_feeder_pkg;

  localparam int FEED_WIDTH = 8;

  typedef enum logic {
    FEED_IDLE  = 1'b0,
    FEED_SHIFT = 1'b1
  } feed_state_e;

  localparam logic [7:0] DETECT_PATTERN = 8'h85;

endpackage

// File: rtl/serial_byte_feeder_if.sv
// Parallel-in handshake plus serial-out stream of the byte feeder.
// master = upstream/observer side, slave = the feeder itself.
interface serial_byte_feeder_if
  import serial_byte_feeder_pkg::*;
#(
  parameter int WIDTH = FEED_WIDTH
);
  logic [WIDTH-1:0] InData;
  logic             InValid;
  logic             InReady;
  logic             OutBit;
  logic             OutValid;
  logic             ByteDone;
  logic             Busy;

  modport master (
    output InData, InValid,
    input  InReady, OutBit, OutValid, ByteDone, Busy
  );

  modport slave (
    input  InData, InValid,
    output InReady, OutBit, OutValid, ByteDone, Busy
  );
endinterface

// File: rtl/serial_byte_feeder.sv
// Serialises accepted words one bit per Clk; first bit the cycle after accept.
// One shifting word plus one held word; InReady drops while the hold slot is full.
module serial_byte_feeder
  import serial_byte_feeder_pkg::*;
#(
  parameter int       WIDTH     = FEED_WIDTH,
  parameter bit       MSB_FIRST = 1'b1,
  parameter bit       IDLE_BIT  = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  serial_byte_feeder_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  feed_state_e      state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             in_ready;
  logic             accept;
  logic             active;
  logic [WIDTH-1:0] sh_next;

  assign active   = (state_q == FEED_SHIFT);
  assign in_ready = !hold_full_q && !Reset;
  assign accept   = bus.InValid && in_ready;

  // Shift toward whichever end feeds OutBit, filling with zero.
  assign sh_next = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      FEED_IDLE: begin
        if (accept) begin
          sh_d    = bus.InData;
          cnt_d   = '0;
          state_d = FEED_SHIFT;
        end
      end
      default: begin
        if (cnt_q != LAST_IDX) begin
          sh_d  = sh_next;
          cnt_d = cnt_q + CW'(1);
          if (accept) begin
            hold_d      = bus.InData;
            hold_full_d = 1'b1;
          end
        end else begin
          cnt_d = '0;
          if (hold_full_q) begin
            sh_d        = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            // Word arriving on the last bit skips the hold slot entirely.
            sh_d = bus.InData;
          end else begin
            state_d = FEED_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= FEED_IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.OutBit   = active ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
  assign bus.OutValid = active;
  assign bus.ByteDone = active && (cnt_q == LAST_IDX);
  assign bus.Busy     = active || hold_full_q;

endmodule
